// File: rtl/hgcal_fc_pkg.sv
// rtl/hgcal_fc_pkg.sv - shared constants for the fast-control L1A arbiter
package hgcal_fc_pkg;

  localparam int NSRC_DEFAULT = 4;

  typedef enum logic [1:0] {
    SRC_PERIODIC = 2'd0,
    SRC_EXTERNAL = 2'd1,
    SRC_CALIB    = 2'd2,
    SRC_RANDOM   = 2'd3
  } l1a_src_e;

  localparam logic [7:0]  GAP_MAX  = 8'd255;
  localparam logic [15:0] DROP_MAX = 16'hFFFF;

endpackage

// File: rtl/hgcal_fc_l1a_window_counter.sv
// rtl/hgcal_fc_l1a_window_counter.sv - sliding-window count of L1A fires over WINDOW BX
module hgcal_fc_l1a_window_counter #(
  parameter int WINDOW = 16,
  parameter int CW     = $clog2(WINDOW + 1)
) (
  input  logic          clk40,
  input  logic          reset,
  input  logic          fire,
  output logic [CW-1:0] count
);

  logic [WINDOW-1:0] hist;

  always_ff @(posedge clk40) begin
    if (reset) begin
      hist  <= '0;
      count <= '0;
    end else begin
      hist  <= {hist[WINDOW-2:0], fire};
      count <= count + CW'(fire) - CW'(hist[WINDOW-1]);
    end
  end

endmodule

// File: rtl/hgcal_fc_l1a_arbiter.sv
// rtl/hgcal_fc_l1a_arbiter.sv - fixed-priority L1A merge with spacing, window, throttle and slot rules
module hgcal_fc_l1a_arbiter
  import hgcal_fc_pkg::*;
#(
  parameter int NSRC   = NSRC_DEFAULT,
  parameter int SRCW   = 2,
  parameter int WINDOW = 16
) (
  input  logic            clk40,
  input  logic            reset,
  input  logic            enable,
  input  logic [NSRC-1:0] src_mask,
  input  logic [NSRC-1:0] req,
  input  logic            throttle,
  input  logic            slot_busy,
  input  logic [7:0]      min_gap,
  input  logic [5:0]      max_in_window,
  input  logic            clear_counters,
  output logic            l1a,
  output logic [SRCW-1:0] l1a_src,
  output logic [NSRC-1:0] pending,
  output logic            veto,
  output logic [31:0]     l1a_count,
  output logic [15:0]     drop_count
);

  localparam int CW = $clog2(WINDOW + 1);
  localparam int DW = $clog2(NSRC + 1);

  logic [NSRC-1:0] eligible;
  logic [NSRC-1:0] pending_next;
  logic [NSRC-1:0] drop_bits;
  logic [DW-1:0]   drop_inc;
  logic [SRCW-1:0] grant_src;
  logic            allow;
  logic            grant;
  logic [7:0]      gap_cnt;
  logic [7:0]      gap_min;
  logic [CW-1:0]   win_cnt;
  logic [16:0]     drop_sum;

  // The window history is fed from the l1a register input, so win_cnt already
  // includes the L1A currently on the output when the next grant is decided.
  hgcal_fc_l1a_window_counter #(
    .WINDOW (WINDOW),
    .CW     (CW)
  ) u_window (
    .clk40 (clk40),
    .reset (reset),
    .fire  (grant),
    .count (win_cnt)
  );

  always_comb begin
    eligible  = enable ? (pending | (req & src_mask)) : '0;
    gap_min   = (min_gap == 8'd0) ? 8'd1 : min_gap;
    allow     = enable && !throttle && !slot_busy && (gap_cnt >= gap_min) &&
                ((max_in_window == 6'd0) || (6'(win_cnt) < max_in_window));
    grant     = allow && (|eligible);
    grant_src = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (eligible[i]) grant_src = SRCW'(i);
    end
    pending_next = grant ? (eligible & ~(NSRC'(1) << grant_src)) : eligible;
    drop_bits    = enable ? (req & src_mask & pending) : '0;
    drop_inc     = '0;
    for (int i = 0; i < NSRC; i++) begin
      drop_inc = drop_inc + DW'(drop_bits[i]);
    end
    drop_sum = {1'b0, drop_count} + 17'(drop_inc);
  end

  always_ff @(posedge clk40) begin
    if (reset) begin
      l1a        <= 1'b0;
      l1a_src    <= '0;
      pending    <= '0;
      veto       <= 1'b0;
      gap_cnt    <= GAP_MAX;
      l1a_count  <= '0;
      drop_count <= '0;
    end else begin
      l1a     <= grant;
      if (grant) l1a_src <= grant_src;
      pending <= pending_next;
      veto    <= |pending_next;
      gap_cnt <= grant ? 8'd1 : ((gap_cnt == GAP_MAX) ? GAP_MAX : gap_cnt + 8'd1);
      if (clear_counters) begin
        l1a_count  <= '0;
        drop_count <= '0;
      end else begin
        l1a_count  <= l1a_count + 32'(grant);
        drop_count <= (drop_sum > 17'(DROP_MAX)) ? DROP_MAX : drop_sum[15:0];
      end
    end
  end

endmodule

// File: tb/tb_hgcal_fc_l1a_arbiter.sv
// tb/tb_hgcal_fc_l1a_arbiter.sv - randomized and directed bench against a timestamp-based model
module tb_hgcal_fc_l1a_arbiter;

  localparam int WINDOW = 16;

  logic        clk40 = 1'b0;
  logic        reset;
  logic        enable;
  logic [3:0]  src_mask;
  logic [3:0]  req;
  logic        throttle;
  logic        slot_busy;
  logic [7:0]  min_gap;
  logic [5:0]  max_in_window;
  logic        clear_counters;
  logic        l1a;
  logic [1:0]  l1a_src;
  logic [3:0]  pending;
  logic        veto;
  logic [31:0] l1a_count;
  logic [15:0] drop_count;

  hgcal_fc_l1a_arbiter #(.NSRC(4), .SRCW(2), .WINDOW(WINDOW)) dut (
    .clk40          (clk40),
    .reset          (reset),
    .enable         (enable),
    .src_mask       (src_mask),
    .req            (req),
    .throttle       (throttle),
    .slot_busy      (slot_busy),
    .min_gap        (min_gap),
    .max_in_window  (max_in_window),
    .clear_counters (clear_counters),
    .l1a            (l1a),
    .l1a_src        (l1a_src),
    .pending        (pending),
    .veto           (veto),
    .l1a_count      (l1a_count),
    .drop_count     (drop_count)
  );

  always #5 clk40 = ~clk40;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Model state: what the DUT outputs should show in the current cycle.
  logic [3:0]  m_pend = '0;
  bit          m_l1a = 0;
  int          m_src = 0;
  logic [31:0] m_cnt = '0;
  int          m_drop = 0;
  int          m_last = -1000;
  int          fired[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    logic [3:0]  elig;
    logic [3:0]  nxt_pend;
    bit          nxt_l1a;
    bit          allow;
    int          nxt_src, wc, gap, mg, nd, g, nxt_drop;
    logic [31:0] nxt_cnt;
    elig = enable ? (m_pend | (req & src_mask)) : 4'b0;
    wc = 0;
    foreach (fired[k]) if (fired[k] > cyc - WINDOW) wc++;
    gap = cyc - m_last + 1;
    if (gap > 255) gap = 255;
    mg = (min_gap == 0) ? 1 : int'(min_gap);
    allow = enable && !throttle && !slot_busy && gap >= mg &&
            (max_in_window == 0 || wc < int'(max_in_window));
    nd = 0;
    if (enable) for (int i = 0; i < 4; i++) if (req[i] && src_mask[i] && m_pend[i]) nd++;
    nxt_l1a = 0;
    nxt_src = m_src;
    nxt_pend = elig;
    if (allow && elig != 0) begin
      g = 0;
      while (!elig[g]) g++;
      nxt_l1a = 1;
      nxt_src = g;
      nxt_pend[g] = 1'b0;
    end
    nxt_cnt  = clear_counters ? 32'd0 : m_cnt + 32'(nxt_l1a);
    nxt_drop = clear_counters ? 0 : ((m_drop + nd > 65535) ? 65535 : m_drop + nd);

    @(posedge clk40);
    #1;
    cyc++;
    if (reset) begin
      m_pend = '0; m_l1a = 0; m_src = 0; m_cnt = '0; m_drop = 0;
      m_last = -1000;
      fired.delete();
    end else begin
      m_pend = nxt_pend; m_l1a = nxt_l1a; m_src = nxt_src;
      m_cnt = nxt_cnt; m_drop = nxt_drop;
      if (nxt_l1a) begin
        m_last = cyc;
        fired.push_back(cyc);
      end
    end
    while (fired.size() > 0 && fired[0] <= cyc - WINDOW) void'(fired.pop_front());

    check("l1a", 32'(l1a), 32'(m_l1a));
    if (m_l1a) check("l1a_src", 32'(l1a_src), 32'(m_src));
    check("pending", 32'(pending), 32'(m_pend));
    check("veto", 32'(veto), 32'(|m_pend));
    check("l1a_count", l1a_count, m_cnt);
    check("drop_count", 32'(drop_count), 32'(m_drop));
  endtask

  int last_a;
  int obs[$];
  int sum;

  initial begin
    reset = 1; enable = 1; src_mask = 4'b1111; req = '0; throttle = 0; slot_busy = 0;
    min_gap = 8'd1; max_in_window = 6'd0; clear_counters = 0;
    repeat (2) tick();
    check("rst_l1a", 32'(l1a), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    reset = 0;
    tick();

    // single request, one cycle latency
    req = 4'b0001; tick(); req = '0;
    check("t1_l1a", 32'(l1a), 32'd1);
    check("t1_src", 32'(l1a_src), 32'd0);
    check("t1_count", l1a_count, 32'd1);
    tick();

    // simultaneous requests resolved by priority
    req = 4'b1010; tick(); req = '0;
    check("t2_src1", 32'(l1a_src), 32'd1);
    check("t2_pend", 32'(pending), 32'b1000);
    check("t2_veto", 32'(veto), 32'd1);
    tick();
    check("t2_src3", 32'(l1a_src), 32'd3);
    check("t2_veto_low", 32'(veto), 32'd0);
    repeat (3) tick();

    // case A: min_gap spacing
    min_gap = 8'd4; last_a = -1;
    req = 4'b0001;
    repeat (40) begin
      tick();
      if (l1a) begin
        if (last_a >= 0) check("gapA_spacing", 32'(cyc - last_a), 32'd4);
        last_a = cyc;
      end
    end
    req = '0; repeat (6) tick();

    // case B: at most 4 in any 16-BX window
    min_gap = 8'd1; max_in_window = 6'd4;
    obs.delete();
    req = 4'b0001;
    repeat (60) begin
      tick();
      obs.push_back(int'(l1a));
      if (obs.size() > WINDOW) void'(obs.pop_front());
      sum = 0;
      foreach (obs[k]) sum += obs[k];
      check("winB_rule", 32'(sum <= 4), 32'd1);
    end
    req = '0; repeat (20) tick();
    max_in_window = 6'd0;

    // throttle then slot_busy hold a pending request
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) throttle = 1; else slot_busy = 1;
      req = 4'b0100; tick(); req = '0;
      repeat (9) begin
        tick();
        check("hold_pend", 32'(pending), 32'b0100);
        check("hold_l1a", 32'(l1a), 32'd0);
      end
      throttle = 0; slot_busy = 0;
      tick();
      check("release_l1a", 32'(l1a), 32'd1);
      check("release_src", 32'(l1a_src), 32'd2);
      repeat (2) tick();
    end

    // masked source is invisible
    src_mask = 4'b1110; req = 4'b0001; tick(); req = '0;
    check("mask_l1a", 32'(l1a), 32'd0);
    tick();
    src_mask = 4'b1111;

    // enable low clears pending
    throttle = 1; req = 4'b0110; tick(); req = '0;
    check("en_pend_set", 32'(pending), 32'b0110);
    enable = 0; tick();
    check("en_pend_clr", 32'(pending), 32'd0);
    enable = 1; throttle = 0; repeat (2) tick();

    // reset discards pending
    throttle = 1; req = 4'b0110; tick(); req = '0;
    reset = 1; tick(); reset = 0; throttle = 0;
    check("rst_mid_pend", 32'(pending), 32'd0);
    repeat (3) begin
      tick();
      check("rst_mid_l1a", 32'(l1a), 32'd0);
    end

    // clear_counters during an l1a cycle
    req = 4'b0001; tick(); req = '0;
    clear_counters = 1; tick(); clear_counters = 0;
    check("clear_cnt", l1a_count, 32'd0);
    tick();

    // randomized phase
    for (int n = 0; n < 3000; n++) begin
      if (n % 100 == 0) begin
        min_gap = 8'($urandom_range(0, 5));
        max_in_window = 6'($urandom_range(0, 6));
      end
      req            = 4'($urandom);
      src_mask       = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b1111;
      throttle       = ($urandom_range(0, 7) == 0);
      slot_busy      = ($urandom_range(0, 7) == 0);
      enable         = ($urandom_range(0, 15) != 0);
      clear_counters = ($urandom_range(0, 199) == 0);
      reset          = ($urandom_range(0, 499) == 0);
      tick();
    end
    reset = 0; clear_counters = 0; enable = 1; src_mask = 4'b1111;
    slot_busy = 0; throttle = 0; req = '0; min_gap = 8'd1; max_in_window = 6'd0;

    // drop saturation
    reset = 1; tick(); reset = 0;
    throttle = 1; req = 4'b1111;
    repeat (16384) tick();
    req = 4'b0011; tick();
    check("drop_fffe", 32'(drop_count), 32'hFFFE);
    req = 4'b0111; tick();
    check("drop_sat", 32'(drop_count), 32'hFFFF);
    req = 4'b1111; tick();
    check("drop_sat_hold", 32'(drop_count), 32'hFFFF);
    req = '0; throttle = 0; repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
